// File: rtl/spike_threshold_mc.sv
// spike_threshold_mc
//   Multi-neuron leaky integrate-and-fire stage. Each accepted partial sum
//   updates the membrane of one neuron: optional constant leak (floored at 0),
//   saturating add, and a strict compare against THRESHOLD. The block then
//   reports the spike bit and the post-update residue and writes the residue
//   back to that neuron's membrane.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer holding valid keeps its payload stable until
// that edge; ready may change freely and never depends on the same side's valid.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   clr             zero all membranes (acted on only while idle)
//   in_valid/ready  partial-sum handshake; in_psum, in_idx carry the payload
//   out_valid/ready result handshake; out_spike, out_idx, out_residue payload
//   busy            high whenever the FSM is not idle
module spike_threshold_mc #(
  parameter int WIDTH       = 8,
  parameter int PSUM_WIDTH  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int THRESHOLD   = 64,
  parameter int RESET_MODE  = 0,
  parameter int LEAK        = 0,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PSUM_WIDTH-1:0] in_psum,
  input  logic [IDX_W-1:0]      in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_spike,
  output logic [IDX_W-1:0]      out_idx,
  output logic [WIDTH-1:0]      out_residue,
  output logic                  busy
);

  localparam logic [WIDTH-1:0] LEAK_W = WIDTH'(LEAK);
  localparam logic [WIDTH:0]   TH_X   = (WIDTH+1)'(THRESHOLD);
  localparam logic [IDX_W:0]   NUM_X  = (IDX_W+1)'(NUM_NEURONS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [WIDTH-1:0]        mem_q [NUM_NEURONS];
  logic [PSUM_WIDTH-1:0]   psum_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    out_valid_q;
  logic                    out_spike_q;
  logic [IDX_W-1:0]        out_idx_q;
  logic [WIDTH-1:0]        out_residue_q;

  // Datapath for the CALC cycle, evaluated from the registered request.
  logic                    in_range;
  logic [WIDTH-1:0]        m;
  logic [WIDTH-1:0]        m_leak;
  logic [WIDTH:0]          sum_x;
  logic [WIDTH-1:0]        sum_sat;
  logic                    spike_d;
  logic [WIDTH-1:0]        residue_d;

  always_comb begin
    in_range  = ({1'b0, idx_q} < NUM_X);
    m         = '0;
    if (in_range) m = mem_q[idx_q];
    m_leak    = (m > LEAK_W) ? (m - LEAK_W) : '0;
    // One extra bit catches the carry so the sum can saturate instead of wrap.
    sum_x     = {1'b0, m_leak} + (WIDTH+1)'(psum_q);
    sum_sat   = sum_x[WIDTH] ? '1 : sum_x[WIDTH-1:0];
    spike_d   = 1'b0;
    residue_d = '0;
    // Out-of-range neurons report no spike and a zero residue.
    if (in_range) begin
      if ({1'b0, sum_sat} > TH_X) begin
        spike_d   = 1'b1;
        residue_d = (RESET_MODE != 0) ? '0 : (sum_sat - TH_X[WIDTH-1:0]);
      end else begin
        residue_d = sum_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
      psum_q        <= '0;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_spike_q   <= 1'b0;
      out_idx_q     <= '0;
      out_residue_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr) begin
            for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
          end else if (in_valid) begin
            psum_q  <= in_psum;
            idx_q   <= in_idx;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          if (in_range) mem_q[idx_q] <= residue_d;
          out_spike_q   <= spike_d;
          out_idx_q     <= idx_q;
          out_residue_q <= residue_d;
          out_valid_q   <= 1'b1;
          state_q       <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !clr;
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_spike   = out_spike_q;
  assign out_idx     = out_idx_q;
  assign out_residue = out_residue_q;

endmodule

// File: doc/spike_threshold_mc.md
# spike_threshold_mc

Clocked, multi-neuron successor to the single-shot spike/residue stage. It holds a membrane potential per neuron, optionally leaks it, and adds incoming partial sums. It compares the result against a threshold, then emits a spike bit plus the new residue while writing the residue back. It sits between the PE accumulator output and the spike output/NoC packetizer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, membrane/residue width (unsigned)
- PSUM_WIDTH, 8, incoming partial-sum width (unsigned, ≤ WIDTH)
- NUM_NEURONS, 4, number of membrane registers (≥1)
- THRESHOLD, 64, firing threshold; spike when potential > THRESHOLD (strict)
- RESET_MODE, 0, 0 = subtract threshold on spike, 1 = reset to zero on spike
- LEAK, 0, constant subtracted from membrane before each update (floored at 0)
- IDX_W, $clog2(NUM_NEURONS) (min 1), index width (derived)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  clear all membranes to 0 (sampled in IDLE only)
- in_valid  in  1  partial sum valid
- in_ready  out  1  block can accept input
- in_psum  in  PSUM_WIDTH  partial sum
- in_idx  in  IDX_W  target neuron index
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_spike  out  1  spike decision
- out_idx  out  IDX_W  neuron index of result
- out_residue  out  WIDTH  post-update membrane value
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, CALC, OUT.
- IDLE: in_ready = !clr. If clr is high, all mem[] are zeroed in that cycle, no input is accepted, and the state stays IDLE. Else if in_valid && in_ready, in_psum and in_idx are registered and the FSM goes to CALC.
- CALC (1 cycle), with m = mem[idx]:
  - m' = (m > LEAK) ? m − LEAK : 0.
  - s = m' + psum, computed at WIDTH+1 bits, then saturated to 2^WIDTH−1.
  - If s > THRESHOLD: spike = 1 and residue = (RESET_MODE ? 0 : s − THRESHOLD). Otherwise spike = 0 and residue = s.
  - mem[idx] ← residue. The output registers load spike/idx/residue. Next state is OUT.
- Out-of-range idx (idx ≥ NUM_NEURONS): no mem write, out_spike = 0, out_residue = 0, out_idx = idx.
- OUT: out_valid = 1. Outputs are held stable until out_ready is seen high; that cycle is the transfer, and the FSM then goes to IDLE. clr is ignored outside IDLE.
- Every input transfer produces exactly one output transfer, in order. No input is dropped while in_ready is low.

## Timing
- Reset (rst high at an edge): state = IDLE, all mem[] = 0, out_valid = 0, out_spike = 0, out_idx = 0, out_residue = 0, busy = 0. in_ready = 1 from the first cycle after reset, unless clr is high.
- rst overrides everything, including mid-CALC and mid-OUT. Any pending result is discarded and its mem write is discarded.
- Latency: input accepted at edge k, CALC at edge k+1, out_valid high after edge k+1 (visible in cycle k+1→k+2). Earliest output transfer is at edge k+2.
- Throughput: one result per 3 cycles with out_ready held high. in_ready is low in CALC and OUT.
- Backpressure: out_valid stays high and out_* stay constant for any number of cycles while out_ready is low.
- out_ready high while out_valid is low has no effect.
- clr and in_valid in the same IDLE cycle: clr wins, and the input is held off (in_ready = 0).

## Test plan
- WIDTH=8, N=4, TH=64, subtract, LEAK=0; after reset send idx0 psum 70, then idx0 psum 10 → (spike 1, residue 6), then (spike 0, residue 16). Each out_valid appears 2 cycles after acceptance.
- Strict threshold: idx1 psum 64 → spike 0, residue 64. Then idx1 psum 1 → spike 1, residue 1. Neurons 0 and 2 remain unchanged (check via 0-psum reads).
- Saturation: idx2 psum 200 → spike 1, residue 136. Then idx2 psum 200 → sum 336 saturates to 255 → spike 1, residue 191.
- Backpressure: hold out_ready low for 5 cycles after out_valid rises. out_* remain constant and in_ready stays 0; the transfer happens on the first out_ready high, and in_ready returns 1 the next cycle.
- Clear and mode:
  - Load idx3 to 30, pulse clr with in_valid high. The input is not accepted that cycle. Then idx3 psum 40 → spike 0, residue 40.
  - With RESET_MODE=1, idx0 psum 100 → spike 1, residue 0.
  - With LEAK=5, idx0 at 3 plus psum 0 → residue 0.
- Reset mid-operation: assert rst during OUT with out_ready low. The next cycle shows out_valid 0, all outputs 0 and in_ready 1. A subsequent idx0 psum 10 → residue 10, which proves the membranes were zeroed.
